// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared encodings and defaults for the SPI transfer arbiter
//
// Purpose: state encoding of the arbiter FSM and the default WAIT timeout.
// Ports: none (package).

package spi_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'h0,
    ARB_LAUNCH = 3'h1,
    ARB_WAIT   = 3'h2,
    ARB_FINISH = 3'h3,
    ARB_ABORT  = 3'h4
  } arb_state_t;

  localparam logic [7:0] DEFAULT_TIMEOUT = 8'd200;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority selector
//
// Purpose: pick the first set bit of req, scanning upward from rr_ptr with
// wrap-around modulo N_REQ.
// Ports:
//   req    in  N_REQ  request vector
//   rr_ptr in  IDX_W  highest-priority index (always < N_REQ)
//   valid  out 1      at least one request is set
//   idx    out IDX_W  selected requester index

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset down to offset 0 so the last hit written
  // is the one closest to rr_ptr. The wrap is an explicit subtract so a
  // non-power-of-two N_REQ never selects an index >= N_REQ.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(N_REQ)) begin
        sum = sum - (IDX_W + 1)'(N_REQ);
      end
      pos = sum[IDX_W-1:0];
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - round-robin sharing of one SPI controller
//
// Purpose: grants one requester at a time, latches its mode and length,
// sequences the controller en/we, waits for done or timeout, and returns a
// per-requester completion or error pulse. Routes controller ss to a
// per-requester active-low select vector.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req/req_cpol/req_cpha      per-requester request and SPI mode
//   req_len                    per-requester length, slice i = [4i+3:4i]
//   gnt                        one-hot grant, LAUNCH through FINISH/ABORT
//   xfer_done/xfer_err         one-cycle completion / timeout pulses
//   ss_n                       per-slave select routed from ctrl_ss
//   ctrl_en/we/rst             controller sequencing (rst active-high)
//   ctrl_cpol/cpha/xfer_len    latched mode and length to the controller
//   ctrl_busy/done/ss          controller status inputs

module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int               N_REQ   = 4,
  parameter int               IDX_W   = 2,
  parameter int               TO_W    = 8,
  parameter logic [TO_W-1:0]  TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_cpol,
  input  logic [N_REQ-1:0]     req_cpha,
  input  logic [4*N_REQ-1:0]   req_len,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     xfer_done,
  output logic [N_REQ-1:0]     xfer_err,
  output logic [N_REQ-1:0]     ss_n,
  output logic                 ctrl_en,
  output logic                 ctrl_we,
  output logic                 ctrl_rst,
  output logic                 ctrl_cpol,
  output logic                 ctrl_cpha,
  output logic [3:0]           ctrl_xfer_len,
  input  logic                 ctrl_busy,
  input  logic                 ctrl_done,
  input  logic                 ctrl_ss
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [TO_W-1:0]  to_cnt;
  logic             rst_hold;
  logic [N_REQ-1:0] one_hot;
  logic             grant_on, done_on, err_on;
  logic             sel_cpol, sel_cpha;
  logic [3:0]       sel_len;

  // Sequencing keys off ctrl_done only; busy is observed but not needed.
  logic unused_busy;
  assign unused_busy = ctrl_busy;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Mux out the picked requester's mode and length.
  always_comb begin
    sel_cpol = 1'b0;
    sel_cpha = 1'b0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_cpol = req_cpol[i];
        sel_cpha = req_cpha[i];
        sel_len  = req_len[4*i +: 4];
      end
    end
  end

  assign next_ptr = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign one_hot  = N_REQ'(1) << gnt_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ARB_IDLE;
      gnt_idx       <= '0;
      rr_ptr        <= '0;
      to_cnt        <= '0;
      ctrl_cpol     <= 1'b0;
      ctrl_cpha     <= 1'b0;
      ctrl_xfer_len <= '0;
      rst_hold      <= 1'b1;
    end else begin
      state    <= state_nxt;
      rst_hold <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_idx       <= pick_idx;
            ctrl_cpol     <= sel_cpol;
            ctrl_cpha     <= sel_cpha;
            ctrl_xfer_len <= sel_len;
          end
        end
        ARB_LAUNCH: to_cnt <= '0;
        ARB_WAIT: begin
          if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ARB_FINISH, ARB_ABORT: rr_ptr <= next_ptr;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl_en   = 1'b0;
    ctrl_we   = 1'b0;
    grant_on  = 1'b0;
    done_on   = 1'b0;
    err_on    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) state_nxt = ARB_LAUNCH;
      end
      ARB_LAUNCH: begin
        ctrl_en   = 1'b1;
        ctrl_we   = 1'b1;
        grant_on  = 1'b1;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        ctrl_en  = 1'b1;
        grant_on = 1'b1;
        // done takes priority over a timeout landing in the same cycle
        if (ctrl_done) begin
          state_nxt = ARB_FINISH;
        end else if (to_cnt == TIMEOUT) begin
          state_nxt = ARB_ABORT;
        end
      end
      ARB_FINISH: begin
        ctrl_en   = 1'b1;
        grant_on  = 1'b1;
        done_on   = 1'b1;
        state_nxt = ARB_IDLE;
      end
      ARB_ABORT: begin
        grant_on  = 1'b1;
        err_on    = 1'b1;
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign gnt       = grant_on ? one_hot : '0;
  assign xfer_done = done_on  ? one_hot : '0;
  assign xfer_err  = err_on   ? one_hot : '0;
  // Controller stays in reset until the first clock after release.
  assign ctrl_rst  = rst_hold | err_on;

  // ctrl_ss is meaningless while the controller is held in reset, so the
  // select vector is forced inactive then.
  always_comb begin
    ss_n = '1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDX_W'(i) && !rst_hold) begin
        ss_n[i] = ctrl_ss;
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb/tb_spi_xfer_arbiter.sv - scoreboard bench for spi_xfer_arbiter

module tb_spi_xfer_arbiter;

  localparam int N = 4;

  typedef struct {
    int         idx;
    logic       cpol;
    logic       cpha;
    logic [3:0] len;
  } launch_t;

  typedef struct {
    int   idx;
    logic err;
    int   waits;
  } comp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req_cpol, req_cpha;
  logic [4*N-1:0] req_len;
  logic [N-1:0]   gnt, xfer_done, xfer_err, ss_n;
  logic           ctrl_en, ctrl_we, ctrl_rst, ctrl_cpol, ctrl_cpha;
  logic [3:0]     ctrl_xfer_len;
  logic           ctrl_busy, ctrl_done, ctrl_ss;

  int tests = 0;
  int fails = 0;
  int model_lat;
  int mcnt;
  bit mbusy;
  int wcnt;

  launch_t lq[$];
  comp_t   cq[$];

  always #5 clk = ~clk;

  spi_xfer_arbiter #(
    .N_REQ   (N),
    .IDX_W   (2),
    .TO_W    (8),
    .TIMEOUT (8'd200)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_cpol      (req_cpol),
    .req_cpha      (req_cpha),
    .req_len       (req_len),
    .gnt           (gnt),
    .xfer_done     (xfer_done),
    .xfer_err      (xfer_err),
    .ss_n          (ss_n),
    .ctrl_en       (ctrl_en),
    .ctrl_we       (ctrl_we),
    .ctrl_rst      (ctrl_rst),
    .ctrl_cpol     (ctrl_cpol),
    .ctrl_cpha     (ctrl_cpha),
    .ctrl_xfer_len (ctrl_xfer_len),
    .ctrl_busy     (ctrl_busy),
    .ctrl_done     (ctrl_done),
    .ctrl_ss       (ctrl_ss)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_launch(input int idx, input logic cpol, input logic cpha, input logic [3:0] len);
    launch_t l;
    l.idx = idx; l.cpol = cpol; l.cpha = cpha; l.len = len;
    lq.push_back(l);
  endtask

  task automatic exp_comp(input int idx, input logic err, input int waits);
    comp_t c;
    c.idx = idx; c.err = err; c.waits = waits;
    cq.push_back(c);
  endtask

  task automatic wait_we(input string name, output int cycles);
    cycles = 0;
    for (int c = 0; c < 20; c++) begin
      if (ctrl_we) return;
      step();
      cycles++;
    end
    check({name, "_we_timeout"}, 32'(ctrl_we), 32'd1);
  endtask

  task automatic wait_fin(input int idx, input bit drop, input string name);
    logic [N-1:0] v, m;
    for (int c = 0; c < 400; c++) begin
      step();
      v = (xfer_done | xfer_err) >> idx;
      if (v[0]) begin
        if (drop) begin
          m = 4'b0001 << idx;
          req = req & ~m;
        end
        return;
      end
    end
    check({name, "_fin_timeout"}, 32'd0, 32'd1);
  endtask

  // Behavioural controller: on a launch it drops ss, counts WAIT cycles and
  // raises done in WAIT cycle number model_lat (0 = never).
  initial begin
    ctrl_done = 1'b0;
    ctrl_ss   = 1'b1;
    ctrl_busy = 1'b0;
    mbusy     = 1'b0;
    mcnt      = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || ctrl_rst) begin
        ctrl_done = 1'b0; ctrl_ss = 1'b1; mbusy = 1'b0; mcnt = 0;
      end else if (ctrl_we) begin
        mbusy = 1'b1; mcnt = 0; ctrl_ss = 1'b0; ctrl_done = 1'b0;
      end else if (mbusy) begin
        if (ctrl_done) begin
          ctrl_done = 1'b0; ctrl_ss = 1'b1; mbusy = 1'b0;
        end else begin
          mcnt++;
          if (model_lat != 0 && mcnt == model_lat) ctrl_done = 1'b1;
        end
      end
      ctrl_busy = mbusy;
    end
  end

  // Monitor: pops launch / completion expectations when the DUT presents them.
  initial begin
    launch_t    l;
    comp_t      c;
    logic [3:0] oh;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wcnt = 0;
      end else if (ctrl_we) begin
        if (lq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_launch: gnt=%b expected no launch", gnt);
        end else begin
          l  = lq.pop_front();
          oh = 4'b0001 << l.idx;
          check("launch_gnt",  32'(gnt), 32'(oh));
          check("launch_cpol", 32'(ctrl_cpol), 32'(l.cpol));
          check("launch_cpha", 32'(ctrl_cpha), 32'(l.cpha));
          check("launch_len",  32'(ctrl_xfer_len), 32'(l.len));
        end
        wcnt = 0;
      end else if (xfer_done != 0 || xfer_err != 0) begin
        if (cq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_completion: done=%b err=%b expected none", xfer_done, xfer_err);
        end else begin
          c  = cq.pop_front();
          oh = 4'b0001 << c.idx;
          check("comp_done",  32'(xfer_done), c.err ? 32'd0 : 32'(oh));
          check("comp_err",   32'(xfer_err),  c.err ? 32'(oh) : 32'd0);
          check("comp_rst",   32'(ctrl_rst),  32'(c.err));
          check("comp_gnt",   32'(gnt),       32'(oh));
          check("comp_waits", 32'(wcnt),      32'(c.waits));
        end
      end else if (ctrl_en) begin
        wcnt++;
      end
    end
  end

  initial begin
    int cyc;
    rst_n = 1'b0; req = '0; req_cpol = '0; req_cpha = '0; req_len = '0;
    model_lat = 3;
    #12;
    check("rst_gnt",  32'(gnt), 32'h0);
    check("rst_done", 32'(xfer_done), 32'h0);
    check("rst_err",  32'(xfer_err), 32'h0);
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_en",   32'(ctrl_en), 32'h0);
    check("rst_we",   32'(ctrl_we), 32'h0);
    check("rst_crst", 32'(ctrl_rst), 32'h1);
    check("rst_cpol", 32'(ctrl_cpol), 32'h0);
    check("rst_cpha", 32'(ctrl_cpha), 32'h0);
    check("rst_len",  32'(ctrl_xfer_len), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_crst_held", 32'(ctrl_rst), 32'h1);
    step();
    check("rst_crst_release", 32'(ctrl_rst), 32'h0);

    // Single requester 2, cpol=1, len=3
    req_cpol = 4'b0100; req_len = 16'h0300; model_lat = 3;
    exp_launch(2, 1'b1, 1'b0, 4'd3);
    exp_comp(2, 1'b0, 3);
    req = 4'b0100;
    wait_we("single", cyc);
    check("single_we_latency", 32'(cyc), 32'd1);
    step();
    check("single_we_once", 32'(ctrl_we), 32'd0);
    check("single_ss_n", 32'(ss_n), 32'hB);
    wait_fin(2, 1'b1, "single");
    step();

    // Contention from rr_ptr=0: order 0,1,2,3,0
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req_cpol = 4'b1010; req_cpha = 4'b0110; req_len = 16'h9752; model_lat = 2;
    exp_launch(0, 1'b0, 1'b0, 4'd2); exp_comp(0, 1'b0, 2);
    exp_launch(1, 1'b1, 1'b1, 4'd5); exp_comp(1, 1'b0, 2);
    exp_launch(2, 1'b0, 1'b1, 4'd7); exp_comp(2, 1'b0, 2);
    exp_launch(3, 1'b1, 1'b0, 4'd9); exp_comp(3, 1'b0, 2);
    exp_launch(0, 1'b0, 1'b0, 4'd2); exp_comp(0, 1'b0, 2);
    req = 4'b1111;
    wait_we("cont", cyc);
    wait_fin(0, 1'b0, "cont0");
    wait_fin(1, 1'b0, "cont1");
    wait_fin(2, 1'b0, "cont2");
    wait_fin(3, 1'b0, "cont3");
    wait_fin(0, 1'b0, "cont4");
    req = '0;
    step(); step();

    // Timeout on requester 0 (rr_ptr=1 here): 201 WAIT cycles then abort
    req_cpol = '0; req_cpha = '0; req_len = 16'h000A; model_lat = 0;
    exp_launch(0, 1'b0, 1'b0, 4'd10); exp_comp(0, 1'b1, 201);
    req = 4'b0001;
    wait_we("tmo", cyc);
    wait_fin(0, 1'b1, "tmo");
    step();

    // rr_ptr advanced to 1: requester 1 first; it drops req during WAIT
    req_cpha = 4'b0010; req_len = 16'h0061; model_lat = 4;
    exp_launch(1, 1'b0, 1'b1, 4'd6); exp_comp(1, 1'b0, 4);
    exp_launch(0, 1'b0, 1'b0, 4'd1); exp_comp(0, 1'b0, 4);
    req = 4'b0011;
    wait_we("drop", cyc);
    step(); step();
    req[1] = 1'b0;
    wait_fin(1, 1'b0, "drop1");
    wait_fin(0, 1'b1, "drop0");
    step();

    // Done in the same cycle as to_cnt==TIMEOUT: done wins
    req_cpol = 4'b1000; req_cpha = 4'b1000; req_len = 16'hF000; model_lat = 201;
    exp_launch(3, 1'b1, 1'b1, 4'd15); exp_comp(3, 1'b0, 201);
    req = 4'b1000;
    wait_we("coll", cyc);
    wait_fin(3, 1'b1, "coll");
    step();

    // Move rr_ptr to 1 so the reset below has something to clear
    req_cpol = '0; req_cpha = '0; req_len = 16'h0004; model_lat = 1;
    exp_launch(0, 1'b0, 1'b0, 4'd4); exp_comp(0, 1'b0, 1);
    req = 4'b0001;
    wait_we("pre", cyc);
    wait_fin(0, 1'b1, "pre");
    step();

    // Reset mid-WAIT on requester 2
    req_len = 16'h0800; model_lat = 0;
    exp_launch(2, 1'b0, 1'b0, 4'd8);
    req = 4'b0100;
    wait_we("mid", cyc);
    step(); step();
    check("mid_ss_n_active", 32'(ss_n), 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt",  32'(gnt), 32'h0);
    check("mid_rst_ss_n", 32'(ss_n), 32'hF);
    check("mid_rst_en",   32'(ctrl_en), 32'h0);
    check("mid_rst_crst", 32'(ctrl_rst), 32'h1);
    req = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    req_len = 16'h3001; model_lat = 2;
    exp_launch(0, 1'b0, 1'b0, 4'd1); exp_comp(0, 1'b0, 2);
    exp_launch(3, 1'b0, 1'b0, 4'd3); exp_comp(3, 1'b0, 2);
    req = 4'b1001;
    wait_we("post", cyc);
    wait_fin(0, 1'b1, "post0");
    wait_fin(3, 1'b1, "post3");
    step(); step(); step();

    check("launch_q_empty", 32'(lq.size()), 32'd0);
    check("comp_q_empty",   32'(cq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
